uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 149 ++++++++++++++
 tb/tb_uart_rx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop line synchroniser, mid-bit sampling, and
// single-cycle valid / framing-error strobes for the last received byte.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       PMOD4,
    input  logic       RS232_Rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int unsigned TIMER_W = 16;
    localparam int unsigned IDX_W   = 3;
    localparam logic [TIMER_W-1:0] FULL_RELOAD = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [TIMER_W-1:0] HALF_RELOAD = TIMER_W'(HALF_BIT - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(7);

    typedef enum logic [2:0] {
        ST_BREAK,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_e;

    logic               s1_q, rx_s_q;
    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               rx_frame_err_q, rx_frame_err_d;
    logic               rx_busy_q, rx_busy_d;

    // Line synchroniser; resets to the idle level.
    always_ff @(posedge clk) begin
        if (PMOD4) begin
            s1_q   <= 1'b1;
            rx_s_q <= 1'b1;
        end else begin
            s1_q   <= RS232_Rx;
            rx_s_q <= s1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (PMOD4) begin
            state_q        <= ST_BREAK;
            timer_q        <= '0;
            bit_idx_q      <= '0;
            shift_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_frame_err_q <= 1'b0;
            rx_busy_q      <= 1'b1;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            bit_idx_q      <= bit_idx_d;
            shift_q        <= shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rx_frame_err_q <= rx_frame_err_d;
            rx_busy_q      <= rx_busy_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        bit_idx_d      = bit_idx_q;
        shift_d        = shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rx_frame_err_d = 1'b0;

        case (state_q)
            // Hold off until the line has been seen high, so a stuck-low line is not a start bit.
            ST_BREAK: begin
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!rx_s_q) begin
                    timer_d = HALF_RELOAD;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (timer_q == '0) begin
                    if (rx_s_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        timer_d   = FULL_RELOAD;
                        bit_idx_d = '0;
                        state_d   = ST_DATA;
                    end
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            ST_DATA: begin
                if (timer_q == '0) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    timer_d = FULL_RELOAD;
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            // Leaves at mid stop bit so an immediately following start bit is caught.
            ST_STOP: begin
                if (timer_q == '0) begin
                    if (rx_s_q) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        rx_frame_err_d = 1'b1;
                        state_d        = ST_BREAK;
                    end
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            default: begin
                state_d = ST_BREAK;
            end
        endcase

        rx_busy_d = (state_d != ST_IDLE);
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_frame_err_q;
    assign rx_busy      = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a serial transmitter model drives frames,
// a negedge monitor records strobes, and expected bytes/latencies come from a frame-level model.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       PMOD4;
    logic       RS232_Rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    uart_rx #(.CLKS_PER_BIT(104)) dut (
        .clk         (clk),
        .PMOD4       (PMOD4),
        .RS232_Rx    (RS232_Rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err),
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   ferr_cnt = 0;
    int   both_cnt = 0;
    logic [7:0] last_good = 8'h00;

    logic [7:0] exp_q[$];
    int         exp_t[$];
    logic [7:0] got_q[$];
    int         got_t[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record every strobe with the cycle it was seen in.
    always @(negedge clk) begin
        if (rx_valid) begin
            got_q.push_back(rx_data);
            got_t.push_back(cyc);
        end
        if (rx_frame_err) ferr_cnt++;
        if (rx_valid && rx_frame_err) both_cnt++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        RS232_Rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drive one 8N1 frame; rst_bit selects a frame bit (0=start) during which PMOD4 pulses for one clock.
    task automatic send(input logic [7:0] b, input int cpb, input logic stop_lvl,
                        input int rst_bit, input logic good);
        logic [9:0] fr;
        fr = {stop_lvl, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RS232_Rx = fr[i];
            if (i == 0 && good) begin
                exp_q.push_back(b);
                exp_t.push_back(cyc);
            end
            for (int j = 0; j < cpb; j++) begin
                PMOD4 = (i == rst_bit && j == cpb / 2);
                @(negedge clk);
            end
        end
        PMOD4 = 1'b0;
        if (good) last_good = b;
        if (rst_bit >= 0) last_good = 8'h00;
    endtask

    // Compare everything the monitor saw since the last call against the model.
    task automatic drain(input string tag, input int exp_ferr);
        int prev_gt, prev_et;
        logic [7:0] eb, gb;
        int et, gt;
        prev_gt = -1;
        prev_et = -1;
        chk({tag, " valid_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            eb = exp_q.pop_front();
            et = exp_t.pop_front();
            gb = got_q.pop_front();
            gt = got_t.pop_front();
            chk({tag, " byte"}, int'(gb), int'(eb));
            chk({tag, " latency_in_990_992"}, int'((gt - et) >= 990 && (gt - et) <= 992), 1);
            if (prev_gt >= 0)
                chk({tag, " spacing"}, gt - prev_gt, et - prev_et);
            prev_gt = gt;
            prev_et = et;
        end
        exp_q.delete();
        exp_t.delete();
        got_q.delete();
        got_t.delete();
        chk({tag, " frame_err_count"}, ferr_cnt, exp_ferr);
        ferr_cnt = 0;
        chk({tag, " rx_data_held"}, int'(rx_data), int'(last_good));
    endtask

    initial begin
        int cpb, gap;
        logic [7:0] rb;

        PMOD4    = 1'b1;
        RS232_Rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset rx_data", int'(rx_data), 0);
        chk("reset rx_valid", int'(rx_valid), 0);
        chk("reset rx_frame_err", int'(rx_frame_err), 0);
        chk("reset rx_busy", int'(rx_busy), 1);
        PMOD4 = 1'b0;
        idle(10);
        chk("idle rx_busy", int'(rx_busy), 0);
        ferr_cnt = 0;

        // Single frame
        send(8'h30, 104, 1'b1, -1, 1'b1);
        idle(20);
        drain("single", 0);

        // Continuous stream with zero idle gap
        for (int k = 0; k < 9; k++) begin
            rb = (k == 8) ? 8'h30 : 8'(8'h30 + k);
            send(rb, 104, 1'b1, -1, 1'b1);
        end
        idle(20);
        chk("stream spacing_model", 10 * 104, 1040);
        drain("stream", 0);

        // Short low glitch on an idle line
        RS232_Rx = 1'b0;
        repeat (20) @(negedge clk);
        idle(200);
        chk("glitch rx_busy", int'(rx_busy), 0);
        drain("glitch", 0);
        send(8'h55, 104, 1'b1, -1, 1'b1);
        idle(20);
        drain("after_glitch", 0);

        // Framing error followed by a long low hold
        send(8'hA5, 104, 1'b0, -1, 1'b0);
        RS232_Rx = 1'b0;
        repeat (2000) @(negedge clk);
        chk("break rx_busy", int'(rx_busy), 1);
        idle(100);
        chk("break_exit rx_busy", int'(rx_busy), 0);
        drain("frame_err", 1);
        send(8'h5A, 104, 1'b1, -1, 1'b1);
        idle(20);
        drain("after_frame_err", 0);

        // Reset pulse during data bit 4
        send(8'hF0, 104, 1'b1, 5, 1'b0);
        idle(50);
        drain("mid_reset", 0);
        send(8'hC3, 104, 1'b1, -1, 1'b1);
        idle(20);
        drain("after_reset", 0);

        // Bit-rate tolerance
        send(8'h00, 101, 1'b1, -1, 1'b1); idle(20);
        send(8'hFF, 101, 1'b1, -1, 1'b1); idle(20);
        send(8'h00, 107, 1'b1, -1, 1'b1); idle(20);
        send(8'hFF, 107, 1'b1, -1, 1'b1); idle(20);
        drain("tolerance", 0);

        // Random bytes, bit rates and gaps
        for (int k = 0; k < 12; k++) begin
            rb  = 8'($urandom);
            cpb = int'($urandom_range(100, 108));
            gap = int'($urandom_range(0, 40));
            send(rb, cpb, 1'b1, -1, 1'b1);
            idle(gap);
        end
        idle(20);
        drain("random", 0);

        chk("valid_and_frame_err_overlap", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
